// File: rtl/icache_fetch_requester.sv
// ---------------------------------------------------------------------------
// icache_fetch_requester
//
// Initiator side of the icache request/response interface. Issues sequential
// fetch requests from RESET_PC with at most one request outstanding, buffers
// the returned instruction words together with their PCs in a small FIFO,
// and discards stale responses after a redirect.
//
// Ports:
//   clock                    - single clock domain
//   reset                    - asynchronous, active-low reset
//   enable                   - permits issuing new requests
//   io_icache_req_valid      - one-cycle request pulse
//   io_icache_req_bits_addr  - fetch address (0 when no request)
//   io_icache_req_bits_data  - constant 0 (read only)
//   io_icache_req_bits_mask  - constant 0 (read)
//   io_icache_resp_valid     - response strobe, one per request
//   io_icache_resp_bits_data - returned instruction word
//   redirect_valid           - flush FIFO and restart fetch
//   redirect_pc              - new fetch PC
//   out_valid                - FIFO head valid
//   out_ready                - consumer accepts the head
//   out_pc                   - PC of the head entry
//   out_inst                 - instruction word of the head entry
//   err                      - sticky: timeout or unsolicited response
// ---------------------------------------------------------------------------
module icache_fetch_requester #(
    parameter logic [31:0] RESET_PC  = 32'h00000200,
    parameter int          ADDR_STEP = 4,
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        io_icache_req_valid,
    output logic [31:0] io_icache_req_bits_addr,
    output logic [31:0] io_icache_req_bits_data,
    output logic [3:0]  io_icache_req_bits_mask,
    input  logic        io_icache_resp_valid,
    input  logic [31:0] io_icache_resp_bits_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_fetchPc;
    logic             r_drop;
    logic             r_err;
    logic [TMO_W-1:0] r_waitCnt;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pcMem   [DEPTH];
    logic [31:0]      r_instMem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_countNext;
    logic             w_hasSpace;
    logic [TMO_W-1:0] w_waitCntNext;
    logic [1:0]       w_stateNext;

    // A redirect flushes the FIFO, so it suppresses both the push of the
    // current response and any same-cycle pop. Space is judged on the
    // occupancy after this cycle's push/pop, so a response arriving while the
    // FIFO is filling can only launch a new request if its word will fit.
    always_comb begin
        w_push = (r_state == ST_WAIT) && io_icache_resp_valid && !r_drop && !redirect_valid;
        w_pop  = (r_count != '0) && out_ready && !redirect_valid;

        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
        w_hasSpace = (w_countNext < CNT_W'(DEPTH));

        w_waitCntNext = (r_waitCnt == TMO_W'(TIMEOUT)) ? r_waitCnt : r_waitCnt + TMO_W'(1);
    end

    // Next-state logic. A stale (dropped or redirected) response always
    // restarts fetch at the new PC, regardless of enable.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!redirect_valid && enable && w_hasSpace) begin
                    w_stateNext = ST_REQ;
                end
            end
            ST_REQ: begin
                w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (io_icache_resp_valid) begin
                    if (redirect_valid || r_drop) begin
                        w_stateNext = ST_REQ;
                    end else if (enable && w_hasSpace) begin
                        w_stateNext = ST_REQ;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, fetch PC, stale-response flag, WAIT timer and the
    // sticky error. A redirect during REQ marks the pulse going out this
    // cycle as stale because it still carries the old address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_fetchPc <= RESET_PC;
            r_drop    <= 1'b0;
            r_err     <= 1'b0;
            r_waitCnt <= '0;
        end else begin
            r_state <= w_stateNext;

            if (r_state == ST_REQ) begin
                r_drop    <= redirect_valid;
                r_waitCnt <= '0;
            end else if (r_state == ST_WAIT) begin
                if (io_icache_resp_valid) begin
                    r_drop <= 1'b0;
                end else begin
                    r_waitCnt <= w_waitCntNext;
                    if (redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                end
            end

            if ((r_state == ST_WAIT && !io_icache_resp_valid && w_waitCntNext == TMO_W'(TIMEOUT)) ||
                (r_state != ST_WAIT && io_icache_resp_valid)) begin
                r_err <= 1'b1;
            end

            if (redirect_valid) begin
                r_fetchPc <= redirect_pc;
            end else if (w_push) begin
                r_fetchPc <= r_fetchPc + 32'(ADDR_STEP);
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
    // power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= w_countNext;
        end
    end

    // FIFO storage; contents only matter while counted, so no reset needed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]   <= r_fetchPc;
            r_instMem[r_wrPtr] <= io_icache_resp_bits_data;
        end
    end

    // Address and head outputs are gated so every output reads 0 in reset.
    always_comb begin
        io_icache_req_valid     = (r_state == ST_REQ);
        io_icache_req_bits_addr = io_icache_req_valid ? r_fetchPc : 32'h0;
        io_icache_req_bits_data = 32'h0;
        io_icache_req_bits_mask = 4'h0;
        out_valid               = (r_count != '0);
        out_pc                  = out_valid ? r_pcMem[r_rdPtr] : 32'h0;
        out_inst                = out_valid ? r_instMem[r_rdPtr] : 32'h0;
        err                     = r_err;
    end

endmodule
